// File: rtl/vending_machine.sv
// vending_machine: single-item coin controller (P1/P5 coins, item pulse, per-peso change train).
// Optional build macro COIN_EDGE_DETECT_EN: coins count only on a 0->1 transition of P1/P5.
`default_nettype none

// ============================================================================
// Module      : vending_machine
// Description : Accumulates 1- and 5-peso coins, vends one item when credit
//               reaches PRICE and returns any excess as 1-cycle change pulses.
//               Macro COIN_EDGE_DETECT_EN selects edge-qualified coin sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine #(
  parameter int PRICE = 3,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic R,
  input  logic P1,
  input  logic P5,
  output logic item,
  output logic change
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPENSE = 1'b1
  } state_t;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  state_t        state_q;
  logic [CW-1:0] credit_q;
  logic [CW-1:0] left_q;
  logic          item_q;
  logic          change_q;

  logic          coin1_d;
  logic          coin5_d;
  logic [2:0]    coin_v_d;
  logic [CW-1:0] total_d;
  logic [CW-1:0] excess_d;

`ifdef COIN_EDGE_DETECT_EN
  logic p1_prev_q;
  logic p5_prev_q;

  // Sample history keeps updating while dispensing so a coin held across
  // the return to IDLE is not counted a second time.
  always_ff @(posedge clk) begin
    if (R) begin
      p1_prev_q <= 1'b0;
      p5_prev_q <= 1'b0;
    end else begin
      p1_prev_q <= P1;
      p5_prev_q <= P5;
    end
  end

  assign coin1_d = P1 & ~p1_prev_q;
  assign coin5_d = P5 & ~p5_prev_q;
`else
  assign coin1_d = P1;
  assign coin5_d = P5;
`endif

  assign coin_v_d = (coin1_d ? 3'd1 : 3'd0) + (coin5_d ? 3'd5 : 3'd0);
  assign total_d  = credit_q + CW'(coin_v_d);
  assign excess_d = total_d - PRICE_C;

  always_ff @(posedge clk) begin
    if (R) begin
      state_q  <= IDLE;
      credit_q <= '0;
      left_q   <= '0;
      item_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      item_q   <= 1'b0;
      change_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin_v_d != 3'd0) begin
            if (total_d < PRICE_C) begin
              credit_q <= total_d;
            end else begin
              item_q   <= 1'b1;
              credit_q <= '0;
              if (excess_d != '0) begin
                // First change pulse rides alongside the item pulse.
                change_q <= 1'b1;
                left_q   <= excess_d - CW'(1);
                state_q  <= (excess_d > CW'(1)) ? DISPENSE : IDLE;
              end
            end
          end
        end
        DISPENSE: begin
          change_q <= 1'b1;
          left_q   <= left_q - CW'(1);
          if (left_q == CW'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign item   = item_q;
  assign change = change_q;

endmodule

`default_nettype wire

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed test-plan sequences plus random coin traffic,
// checked cycle by cycle against a peso-counting reference model.
`default_nettype none

module tb_vending_machine;

  localparam int PRICE = 3;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic R   = 1'b0;
  logic P1  = 1'b0;
  logic P5  = 1'b0;
  logic item;
  logic change;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pesos of credit and pesos of change still owed.
  int m_credit = 0;
  int m_owed   = 0;
  int m_prev1  = 0;
  int m_prev5  = 0;
  int exp_item = 0;
  int exp_chg  = 0;

  vending_machine #(.PRICE(PRICE), .CW(CW)) dut (
    .clk    (clk),
    .R      (R),
    .P1     (P1),
    .P5     (P5),
    .item   (item),
    .change (change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input int r, input int a, input int b);
    int e1, e5, v, total;
`ifdef COIN_EDGE_DETECT_EN
    e1 = (a != 0 && m_prev1 == 0) ? 1 : 0;
    e5 = (b != 0 && m_prev5 == 0) ? 1 : 0;
    m_prev1 = (r != 0) ? 0 : a;
    m_prev5 = (r != 0) ? 0 : b;
`else
    e1 = a;
    e5 = b;
`endif
    exp_item = 0;
    exp_chg  = 0;
    if (r != 0) begin
      m_credit = 0;
      m_owed   = 0;
    end else if (m_owed > 0) begin
      exp_chg = 1;
      m_owed--;
    end else begin
      v = e1 + 5 * e5;
      if (v > 0) begin
        total = m_credit + v;
        if (total < PRICE) begin
          m_credit = total;
        end else begin
          exp_item = 1;
          m_credit = 0;
          if (total - PRICE > 0) begin
            exp_chg = 1;
            m_owed  = total - PRICE - 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input int r, input int a, input int b, input string tag);
    R  = r[0];
    P1 = a[0];
    P5 = b[0];
    @(posedge clk);
    model_edge(r, a, b);
    #1;
    check({tag, ".item"},   int'(item),   exp_item);
    check({tag, ".change"}, int'(change), exp_chg);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, tag);
  endtask

  initial begin
    // Reset state
    cycle(1, 1, 1, "reset");
    cycle(1, 0, 0, "reset");

    // P5 alone: item + 2 change pulses
    cycle(0, 0, 1, "p5");
    idle(4, "p5");

    // Three separate P1 pulses: vend on the third, no change
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, "3xp1");
      idle(2, "3xp1");
    end

    // P1, P1, P5 -> item + 4 pulses; P1 during pulses ignored
    cycle(0, 1, 0, "p1p1p5");
    cycle(0, 1, 0, "p1p1p5");
    cycle(0, 0, 1, "p1p1p5");
    cycle(0, 1, 0, "p1p1p5");
    cycle(0, 1, 0, "p1p1p5");
    cycle(0, 1, 0, "p1p1p5");
    idle(2, "p1p1p5");
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, "revend");
      cycle(0, 0, 0, "revend");
    end
    idle(2, "revend");

    // P1 then P5; then both coins in one cycle
    cycle(0, 1, 0, "p1p5");
    cycle(0, 0, 1, "p1p5");
    idle(4, "p1p5");
    cycle(0, 1, 1, "both");
    idle(4, "both");

    // Reset clears credit
    cycle(0, 1, 0, "rstmid");
    cycle(1, 0, 0, "rstmid");
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, "rstmid");
      cycle(0, 0, 0, "rstmid");
    end

    // Reset in the middle of a change train
    cycle(0, 0, 1, "rstdisp");
    cycle(0, 0, 1, "rstdisp");
    cycle(1, 0, 0, "rstdisp");
    idle(3, "rstdisp");

    // P1 held for 5 cycles
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, "hold");
    idle(3, "hold");
    cycle(0, 1, 0, "hold");
    idle(3, "hold");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r, a, b;
      r = ($urandom_range(0, 63) == 0) ? 1 : 0;
      a = ($urandom_range(0, 3) == 0) ? 1 : 0;
      b = ($urandom_range(0, 9) == 0) ? 1 : 0;
      cycle(r, a, b, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Single-item coin-operated vending controller accepting 1-peso (P1) and 5-peso (P5) coins; item price is PRICE pesos (default 3).
- When accumulated credit reaches PRICE, it vends one item (1-cycle pulse) and returns any excess as a train of 1-cycle change pulses, one pulse per peso.
- Sits between a coin-acceptor front end (already synchronised to clk) and the dispense/change actuators.

Parameters:
- PRICE, 3, item price in pesos; legal range 1..9.
- CW, 4, credit/change counter width; must hold PRICE-1+6 (default max 8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- R  input  1  reset, synchronous, active-high.
- P1  input  1  1-peso coin inserted (synchronous to clk).
- P5  input  1  5-peso coin inserted (synchronous to clk).
- item  output  1  registered; high for exactly one cycle per vend.
- change  output  1  registered; one 1-cycle high pulse per peso of change.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising edge with R=1, credit=0, change_left=0, state=IDLE, item=0, change=0. R overrides all coin inputs in that cycle. Reset mid-dispense abandons any remaining change.
- States:
  - IDLE: credit 0..PRICE-1, coins accepted.
  - DISPENSE: change_left>0, coins ignored.
- Coin value per edge: v = P1*1 + P5*5. P1 and P5 both high counts as 6.
- In IDLE at an edge with v>0, total = credit + v (CW bits, no overflow by construction):
  - total < PRICE: credit <= total; item=0; change=0.
  - total >= PRICE: item <= 1 for the next cycle; credit <= 0; c = total - PRICE.
    - c = 0: stay IDLE.
    - c > 0: change <= 1 in the same cycle as item; change_left <= c-1; go to DISPENSE if c-1 > 0, else stay IDLE.
- In DISPENSE at each edge: change <= 1, change_left decrements, item <= 0. Return to IDLE on the edge that issues the last pulse.
- Coins arriving during DISPENSE are discarded (no credit) in every build.
- Latency: item and first change pulse appear in the cycle immediately after the coin-sampling edge. Total change pulses equal c, on consecutive cycles.
- With no coin and not dispensing: item=0, change=0, credit held.

Optional Feature:
- Macro COIN_EDGE_DETECT_EN.
- Defined:
  - P1/P5 pass through internal registers; a coin counts only on a 0->1 transition between consecutive samples.
  - A coin held high for many cycles counts once.
  - Edge registers are cleared by R.
- Undefined: every cycle a coin input is high at a rising edge counts as one coin.

Test Plan:
- Reset then P5 for 1 cycle -> next cycle item=1, change=1; following cycle change=1, item=0; then both 0 (2 pulses total), credit 0.
- Three separate P1 pulses -> no output after first two; after third, item=1 for one cycle, change never pulses.
- P1, P1, then P5 -> item=1 plus 4 consecutive change pulses starting with the item cycle; P1 inserted during pulses 2-4 yields no credit (a further 3xP1 is needed to vend again).
- P1 then P5 -> item=1 and 3 change pulses. P1 and P5 asserted in the same cycle from credit 0 -> item plus 3 change pulses.
- P1 (credit 1) then R=1 for one cycle -> item=0, change=0, credit cleared; two further P1 do not vend, a third does.
- COIN_EDGE_DETECT_EN defined: P1 held high 5 cycles -> counts once, no vend. Undefined: same stimulus -> vend on the 3rd high cycle, credit 2 after the 5th.
